// File: rtl/pool2d_engine_pkg.sv
// Shared encodings and elaboration-time helpers for the 2-D pooling engine.
package pool_pkg;

   localparam logic POOL_MAX = 1'b0;
   localparam logic POOL_AVG = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_WRITE,
      ST_DONE
   } pool_state_e;

   function automatic int out_dim(input int img, input int k, input int stride);
      return (img - k) / stride + 1;
   endfunction

   function automatic int sum_w(input int data_w, input int k);
      return data_w + $clog2(k * k + 1);
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pool2d_engine_window_acc.sv
// Per-window accumulator: running unsigned max and running sum with constant divide.
module pool_window_acc
   import pool_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int K      = 3
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              valid,
   input  logic [DATA_W-1:0] data,
   input  logic              mode,
   output logic [DATA_W-1:0] result
);

   localparam int SW = sum_w(DATA_W, K);
   localparam int KK = K * K;

   logic [DATA_W-1:0] max_q;
   logic [SW-1:0]     sum_q;
   logic [SW-1:0]     avg;

   always_ff @(posedge clk) begin
      if (clear) begin
         max_q <= '0;
         sum_q <= '0;
      end else if (valid) begin
         if (data > max_q) max_q <= data;
         sum_q <= sum_q + SW'(data);
      end
   end

   // A full window of max-valued pixels divides back to exactly the max value.
   assign avg    = sum_q / SW'(KK);
   assign result = (mode == POOL_AVG) ? DATA_W'(avg) : max_q;

endmodule

// File: rtl/pool2d_engine.sv
// Multi-channel K x K max/average pooling engine between two BRAM ports.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start after reset
// ST_ISSUE | one input read per cycle over the K x K window
// ST_DRAIN | down-counter waits RD_LAT cycles for the last read data
// ST_WRITE | single-cycle output write, advance window indices
// ST_DONE  | run complete, done held until the next start
module pool2d_engine
   import pool_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int IMG_W    = 7,
   parameter int IMG_H    = 7,
   parameter int CHANNELS = 1,
   parameter int K        = 3,
   parameter int STRIDE   = 2,
   parameter int RD_LAT   = 2,
   parameter int ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic              in_ren,
   output logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_dout,
   output logic              out_wen,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_din
);

   localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
   localparam int OUT_H = out_dim(IMG_H, K, STRIDE);
   localparam int CW    = idx_w(CHANNELS);
   localparam int OXW   = idx_w(OUT_W);
   localparam int OYW   = idx_w(OUT_H);
   localparam int KW    = idx_w(K);
   localparam int DW    = idx_w(RD_LAT);

   pool_state_e       state;
   logic              mode_q;
   logic [CW-1:0]     c_idx;
   logic [OYW-1:0]    oy_idx;
   logic [OXW-1:0]    ox_idx;
   logic [KW-1:0]     j_idx;
   logic [KW-1:0]     i_idx;
   logic [DW-1:0]     drain_cnt;
   logic [RD_LAT-1:0] vld_sr;

   logic              i_last, j_last, ox_last, oy_last, c_last, run_last;
   logic [CW-1:0]     nx_c;
   logic [OYW-1:0]    nx_oy;
   logic [OXW-1:0]    nx_ox;
   logic              acc_clear;

   function automatic logic [ADDR_W-1:0] rd_addr(
      input logic [CW-1:0]  cv,
      input logic [OYW-1:0] oyv,
      input logic [OXW-1:0] oxv,
      input logic [KW-1:0]  jv,
      input logic [KW-1:0]  iv
   );
      return ADDR_W'(cv) * ADDR_W'(IMG_W * IMG_H)
           + (ADDR_W'(oyv) * ADDR_W'(STRIDE) + ADDR_W'(jv)) * ADDR_W'(IMG_W)
           + ADDR_W'(oxv) * ADDR_W'(STRIDE) + ADDR_W'(iv);
   endfunction

   function automatic logic [ADDR_W-1:0] wr_addr(
      input logic [CW-1:0]  cv,
      input logic [OYW-1:0] oyv,
      input logic [OXW-1:0] oxv
   );
      return ADDR_W'(cv) * ADDR_W'(OUT_W * OUT_H)
           + ADDR_W'(oyv) * ADDR_W'(OUT_W) + ADDR_W'(oxv);
   endfunction

   assign i_last   = (i_idx == KW'(K - 1));
   assign j_last   = (j_idx == KW'(K - 1));
   assign ox_last  = (ox_idx == OXW'(OUT_W - 1));
   assign oy_last  = (oy_idx == OYW'(OUT_H - 1));
   assign c_last   = (c_idx == CW'(CHANNELS - 1));
   assign run_last = ox_last && oy_last && c_last;

   always_comb begin
      nx_ox = ox_idx + OXW'(1);
      nx_oy = oy_idx;
      nx_c  = c_idx;
      if (ox_last) begin
         nx_ox = '0;
         nx_oy = oy_idx + OYW'(1);
         if (oy_last) begin
            nx_oy = '0;
            nx_c  = c_idx + CW'(1);
         end
      end
   end

   // Clearing on the write cycle leaves the accumulator empty for the next window.
   assign acc_clear = rst || (state == ST_WRITE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         in_ren    <= 1'b0;
         in_addr   <= '0;
         out_wen   <= 1'b0;
         out_addr  <= '0;
         mode_q    <= POOL_MAX;
         c_idx     <= '0;
         oy_idx    <= '0;
         ox_idx    <= '0;
         j_idx     <= '0;
         i_idx     <= '0;
         drain_cnt <= '0;
         vld_sr    <= '0;
      end else begin
         for (int k = RD_LAT - 1; k > 0; k--) vld_sr[k] <= vld_sr[k-1];
         vld_sr[0] <= in_ren;
         out_wen   <= 1'b0;

         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state   <= ST_ISSUE;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  mode_q  <= mode;
                  c_idx   <= '0;
                  oy_idx  <= '0;
                  ox_idx  <= '0;
                  j_idx   <= '0;
                  i_idx   <= '0;
                  in_ren  <= 1'b1;
                  in_addr <= '0;
               end
            end

            ST_ISSUE: begin
               if (i_last) begin
                  i_idx <= '0;
                  if (j_last) begin
                     j_idx     <= '0;
                     in_ren    <= 1'b0;
                     drain_cnt <= DW'(RD_LAT - 1);
                     state     <= ST_DRAIN;
                  end else begin
                     j_idx   <= j_idx + KW'(1);
                     in_addr <= rd_addr(c_idx, oy_idx, ox_idx, j_idx + KW'(1), '0);
                  end
               end else begin
                  i_idx   <= i_idx + KW'(1);
                  in_addr <= rd_addr(c_idx, oy_idx, ox_idx, j_idx, i_idx + KW'(1));
               end
            end

            ST_DRAIN: begin
               if (drain_cnt == '0) begin
                  out_wen  <= 1'b1;
                  out_addr <= wr_addr(c_idx, oy_idx, ox_idx);
                  state    <= ST_WRITE;
               end else begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
            end

            ST_WRITE: begin
               if (run_last) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  c_idx   <= nx_c;
                  oy_idx  <= nx_oy;
                  ox_idx  <= nx_ox;
                  in_ren  <= 1'b1;
                  in_addr <= rd_addr(nx_c, nx_oy, nx_ox, '0, '0);
                  state   <= ST_ISSUE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   pool_window_acc #(
      .DATA_W(DATA_W),
      .K     (K)
   ) u_acc (
      .clk   (clk),
      .clear (acc_clear),
      .valid (vld_sr[RD_LAT-1]),
      .data  (in_dout),
      .mode  (mode_q),
      .result(out_din)
   );

endmodule

// File: tb/tb_pool2d_engine.sv
// Directed bench: two engines (1 and 2 channels) on BRAM models, scoreboarded writes.
module tb_pool2d_engine;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } exp_t;

   localparam int MAX_RAMP[9] = '{16, 18, 20, 30, 32, 34, 44, 46, 48};
   localparam int AVG_RAMP[9] = '{8, 10, 12, 22, 24, 26, 36, 38, 40};
   localparam int MAX_INV[9]  = '{255, 253, 251, 241, 239, 237, 227, 225, 223};

   logic clk = 1'b0;
   logic rst, start, mode, sel;

   logic        busy_a, done_a, ren_a, wen_a, busy_b, done_b, ren_b, wen_b;
   logic [15:0] raddr_a, waddr_a, raddr_b, waddr_b;
   logic [7:0]  dout_a, din_a, dout_b, din_b;
   logic [7:0]  mem_a [0:48];
   logic [7:0]  mem_b [0:97];
   logic [7:0]  pipe_a [0:1];
   logic [7:0]  pipe_b [0:1];

   logic        s_busy, s_done, s_ren, s_wen;
   logic [15:0] s_raddr, s_waddr;
   logic [7:0]  s_din;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pool2d_engine u_dut_a (
      .clk(clk), .rst(rst), .start(start & ~sel), .mode(mode),
      .busy(busy_a), .done(done_a), .in_ren(ren_a), .in_addr(raddr_a),
      .in_dout(dout_a), .out_wen(wen_a), .out_addr(waddr_a), .out_din(din_a)
   );

   pool2d_engine #(.CHANNELS(2)) u_dut_b (
      .clk(clk), .rst(rst), .start(start & sel), .mode(mode),
      .busy(busy_b), .done(done_b), .in_ren(ren_b), .in_addr(raddr_b),
      .in_dout(dout_b), .out_wen(wen_b), .out_addr(waddr_b), .out_din(din_b)
   );

   // Two-cycle read BRAMs; idle or out-of-range slots return a large junk value.
   always @(posedge clk) begin
      pipe_a[0] <= (ren_a && int'(raddr_a) < 49) ? mem_a[int'(raddr_a)] : 8'hA5;
      pipe_a[1] <= pipe_a[0];
      pipe_b[0] <= (ren_b && int'(raddr_b) < 98) ? mem_b[int'(raddr_b)] : 8'hA5;
      pipe_b[1] <= pipe_b[0];
   end
   assign dout_a = pipe_a[1];
   assign dout_b = pipe_b[1];

   assign s_busy  = sel ? busy_b  : busy_a;
   assign s_done  = sel ? done_b  : done_a;
   assign s_ren   = sel ? ren_b   : ren_a;
   assign s_wen   = sel ? wen_b   : wen_a;
   assign s_raddr = sel ? raddr_b : raddr_a;
   assign s_waddr = sel ? waddr_b : waddr_a;
   assign s_din   = sel ? din_b   : din_a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model(input bit sv, input int c, input int oy, input int ox, input logic m);
      int mx = 0;
      int sum = 0;
      int v, idx;
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < 3; i++) begin
            idx = c * 49 + (oy * 2 + j) * 7 + ox * 2 + i;
            v = sv ? int'(mem_b[idx]) : int'(mem_a[idx]);
            if (v > mx) mx = v;
            sum += v;
         end
      return m ? sum / 9 : mx;
   endfunction

   task automatic push(input int a, input int d);
      exp_t e;
      e.addr = 16'(a);
      e.data = 8'(d);
      q.push_back(e);
   endtask

   task automatic push_model(input bit sv, input logic m, input int nch);
      for (int c = 0; c < nch; c++)
         for (int oy = 0; oy < 3; oy++)
            for (int ox = 0; ox < 3; ox++)
               push(c * 9 + oy * 3 + ox, model(sv, c, oy, ox, m));
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_ctl"}, {28'd0, s_busy, s_done, s_ren, s_wen}, 32'd0);
      chk({tag, "_in_addr"}, s_raddr, 32'd0);
      chk({tag, "_out_addr"}, s_waddr, 32'd0);
      chk({tag, "_out_din"}, s_din, 32'd0);
   endtask

   // Start at cycle 0; optional start pulse (pulse_at) or reset (rst_at) mid-run.
   task automatic run(input bit sv, input logic m, input int pulse_at, input int rst_at,
                      input int exp_done, input int exp_reads);
      int cyc, rens, wens;
      bit aborted;
      exp_t e;
      sel = sv;
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      @(negedge clk);
      start = 1'b0;
      mode  = ~m;
      cyc = 1; rens = 0; aborted = 0;
      chk("first_read", {15'd0, s_ren, s_raddr}, {15'd0, 1'b1, 16'd0});
      chk("busy_on", {30'd0, s_busy, s_done}, 32'd2);
      while (!s_done && !aborted && cyc < 400) begin
         start = (cyc == pulse_at);
         if (s_ren) rens++;
         if (s_wen) begin
            if (q.size() == 0) chk("extra_write", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               chk("out_addr", s_waddr, e.addr);
               chk("out_din", s_din, e.data);
            end
         end
         if (cyc == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_reset_outs("mid_rst");
            wens = 0;
            repeat (30) begin
               @(negedge clk);
               if (s_wen || s_busy) wens++;
            end
            chk("quiet_after_rst", wens, 32'd0);
            q.delete();
            aborted = 1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      if (!aborted) begin
         chk("done_cycle", cyc, exp_done);
         chk("busy_at_done", {31'd0, s_busy}, 32'd0);
         chk("read_count", rens, exp_reads);
         chk("queue_empty", q.size(), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; sel = 1'b0;
      for (int r = 0; r < 7; r++)
         for (int col = 0; col < 7; col++) begin
            mem_a[r * 7 + col]      = 8'(r * 7 + col);
            mem_b[r * 7 + col]      = 8'(r * 7 + col);
            mem_b[49 + r * 7 + col] = 8'(255 - (r * 7 + col));
         end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_outs("reset_a");
      sel = 1'b1;
      #1 check_reset_outs("reset_b");

      // max over ramp
      for (int n = 0; n < 9; n++) push(n, MAX_RAMP[n]);
      run(0, 1'b0, -1, -1, 109, 81);

      // average over ramp, started from DONE
      for (int n = 0; n < 9; n++) push(n, AVG_RAMP[n]);
      run(0, 1'b1, -1, -1, 109, 81);

      // two channels, second channel inverted ramp
      for (int n = 0; n < 9; n++) push(n, MAX_RAMP[n]);
      for (int n = 0; n < 9; n++) push(9 + n, MAX_INV[n]);
      run(1, 1'b0, -1, -1, 217, 162);
      push_model(1, 1'b1, 2);
      run(1, 1'b1, -1, -1, 217, 162);

      // stray start (with flipped mode) while busy changes nothing
      push_model(0, 1'b0, 1);
      run(0, 1'b0, 30, -1, 109, 81);

      // saturated input, average must not overflow
      for (int n = 0; n < 49; n++) mem_a[n] = 8'd255;
      for (int n = 0; n < 9; n++) push(n, 255);
      run(0, 1'b1, -1, -1, 109, 81);

      // reset at cycle 40, then a clean run from IDLE
      for (int n = 0; n < 49; n++) mem_a[n] = 8'(n * 37 % 251);
      push_model(0, 1'b0, 1);
      run(0, 1'b0, -1, 40, 0, 0);
      push_model(0, 1'b1, 1);
      run(0, 1'b1, -1, -1, 109, 81);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
